// File: rtl/vga_sync_pulses_pkg.sv
// Shared VGA constants: 640x480@60 timing defaults and the count width.
// Also used by vga_sync_add_porch.
package vga_sync_pulses_pkg;

    localparam int unsigned VGA_COUNT_W         = 10;
    localparam int unsigned VGA_FRAME_COUNT_W   = 8;

    localparam int unsigned VGA_VISIBLE_COLUMNS = 640;
    localparam int unsigned VGA_VISIBLE_ROWS    = 480;
    localparam int unsigned VGA_TOTAL_COLUMNS   = 800;
    localparam int unsigned VGA_TOTAL_ROWS      = 525;

    typedef logic [VGA_COUNT_W-1:0]       vga_count_t;
    typedef logic [VGA_FRAME_COUNT_W-1:0] vga_frame_count_t;

endpackage

// File: rtl/vga_wrap_counter.sv
// Modulo-MODULUS up-counter with enable; o_wrap flags the enabled cycle that
// returns the count to zero, o_count_next is the value loaded on the next edge.
module vga_wrap_counter
    import vga_sync_pulses_pkg::*;
#(
    parameter int unsigned MODULUS = VGA_TOTAL_COLUMNS
)
(
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_En,
    output vga_count_t o_count,
    output vga_count_t o_count_next,
    output logic       o_wrap
);

    localparam vga_count_t LAST = vga_count_t'(MODULUS - 1);

    vga_count_t count_q;
    vga_count_t count_d;
    logic       wrap;

    always_comb begin
        wrap    = i_En && (count_q == LAST);
        count_d = count_q;
        if (i_Rst) begin
            count_d = '0;
        end else if (wrap) begin
            count_d = '0;
        end else if (i_En) begin
            count_d = count_q + vga_count_t'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count      = count_q;
    assign o_count_next = count_d;
    assign o_wrap       = wrap;

endmodule

// File: rtl/vga_sync_pulses.sv
// Column/row scan counters with visible-area syncs and a frame-start pulse.
// Optional frame counter output enabled by defining VGA_FRAME_COUNT_EN.
module vga_sync_pulses
    import vga_sync_pulses_pkg::*;
#(
    parameter int unsigned c_VISIBLE_COLUMNS = VGA_VISIBLE_COLUMNS,
    parameter int unsigned c_VISIBLE_ROWS    = VGA_VISIBLE_ROWS,
    parameter int unsigned c_TOTAL_COLUMNS   = VGA_TOTAL_COLUMNS,
    parameter int unsigned c_TOTAL_ROWS      = VGA_TOTAL_ROWS
)
(
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Enable,
    output logic             o_HSync,
    output logic             o_VSync,
    output vga_count_t       o_ColCount,
    output vga_count_t       o_RowCount,
    output logic             o_FrameStart
`ifdef VGA_FRAME_COUNT_EN
    ,
    output vga_frame_count_t o_FrameCount
`endif
);

    localparam vga_count_t VIS_COLS = vga_count_t'(c_VISIBLE_COLUMNS);
    localparam vga_count_t VIS_ROWS = vga_count_t'(c_VISIBLE_ROWS);

    vga_count_t col;
    vga_count_t col_next;
    vga_count_t row;
    vga_count_t row_next;
    logic       col_wrap;
    logic       row_wrap;

    vga_wrap_counter #(.MODULUS(c_TOTAL_COLUMNS)) u_col (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_En         (i_Enable),
        .o_count      (col),
        .o_count_next (col_next),
        .o_wrap       (col_wrap)
    );

    // Rows advance only on the enabled column wrap, so row_wrap marks end of frame.
    vga_wrap_counter #(.MODULUS(c_TOTAL_ROWS)) u_row (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_En         (col_wrap),
        .o_count      (row),
        .o_count_next (row_next),
        .o_wrap       (row_wrap)
    );

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic frame_start_q, frame_start_d;

    // Syncs are registered from the counters' next values to stay skew-free.
    always_comb begin
        hsync_d       = (col_next < VIS_COLS);
        vsync_d       = (row_next < VIS_ROWS);
        frame_start_d = row_wrap;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    vga_frame_count_t frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (row_wrap) begin
            frame_count_d = frame_count_q + vga_frame_count_t'(1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign o_FrameCount = frame_count_q;
`endif

    assign o_HSync      = hsync_q;
    assign o_VSync      = vsync_q;
    assign o_ColCount   = col;
    assign o_RowCount   = row;
    assign o_FrameStart = frame_start_q;

endmodule

// File: tb/tb_vga_sync_pulses.sv
// Scoreboard bench for vga_sync_pulses using a reduced raster so whole frames
// (and 256+ frames when VGA_FRAME_COUNT_EN is defined) fit in a short run.
module tb_vga_sync_pulses;

    localparam int VC = 10;
    localparam int VR = 5;
    localparam int TC = 13;
    localparam int TR = 8;
    localparam int FRAME = TC * TR;

    logic       clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_Enable = 1'b0;
    logic       o_HSync, o_VSync, o_FrameStart;
    logic [9:0] o_ColCount, o_RowCount;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] o_FrameCount;
`endif

    vga_sync_pulses #(
        .c_VISIBLE_COLUMNS (VC),
        .c_VISIBLE_ROWS    (VR),
        .c_TOTAL_COLUMNS   (TC),
        .c_TOTAL_ROWS      (TR)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (i_Rst),
        .i_Enable     (i_Enable),
        .o_HSync      (o_HSync),
        .o_VSync      (o_VSync),
        .o_ColCount   (o_ColCount),
        .o_RowCount   (o_RowCount),
        .o_FrameStart (o_FrameStart)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .o_FrameCount (o_FrameCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int col;
        int row;
        bit hs;
        bit vs;
        bit fs;
        int fc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   started = 1'b0;
    bit   done = 1'b0;

    // Reference model: linear pixel position within the frame plus frame tally.
    int   m_pix = 0;
    int   m_frames = 0;
    int   m_fs_seen = 0;

    task automatic step(input bit en, input bit rst);
        exp_t e;
        @(negedge clk);
        i_Enable = en;
        i_Rst    = rst;
        e.fs = 1'b0;
        if (rst) begin
            m_pix    = 0;
            m_frames = 0;
        end else if (en) begin
            m_pix = (m_pix + 1) % FRAME;
            if (m_pix == 0) begin
                e.fs = 1'b1;
                m_frames++;
                m_fs_seen++;
            end
        end
        e.col = m_pix % TC;
        e.row = m_pix / TC;
        e.hs  = (e.col < VC);
        e.vs  = (e.row < VR);
        e.fc  = m_frames % 256;
        q.push_back(e);
        started = 1'b1;
    endtask

    task automatic report(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp_v, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                report("col",         int'(o_ColCount),   e.col);
                report("row",         int'(o_RowCount),   e.row);
                report("hsync",       int'(o_HSync),      int'(e.hs));
                report("vsync",       int'(o_VSync),      int'(e.vs));
                report("frame_start", int'(o_FrameStart), int'(e.fs));
`ifdef VGA_FRAME_COUNT_EN
                report("frame_count", int'(o_FrameCount), e.fc);
`endif
            end else if (started && !done) begin
                report("scoreboard_underflow", 0, 1);
            end
        end
    end

    initial begin : stimulus
        int guard;
        int fs_before;

        repeat (3) step(1'b1, 1'b1);

        // Random enable with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, ($urandom % 600) == 0);
        end

        // Enable toggling every cycle.
        for (int i = 0; i < 400; i++) begin
            step(i[0] == 1'b0, 1'b0);
        end

        // Reset mid-frame at a known position, then first enabled cycle -> column 1.
        guard = 0;
        while (m_pix != (3 * TC + 7) && guard < 2 * FRAME) begin
            step(1'b1, 1'b0);
            guard++;
        end
        report("reach_mid_frame", guard < 2 * FRAME ? 1 : 0, 1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);

        // Long continuous run: exercises frame wrap and the 255 -> 0 frame count wrap.
        fs_before = m_fs_seen;
        for (int i = 0; i < 257 * FRAME + 20; i++) begin
            step(1'b1, 1'b0);
        end
        report("model_frame_pulses", m_fs_seen - fs_before, 257);

        @(posedge clk);
        #2;
        done = 1'b1;
        report("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
